// File: rtl/trigger_window_gen.sv
// Turns an asynchronous trigger level into a fixed-length acquisition window on clk160.
// It also provides an optional holdoff, an event index, and accepted/lost trigger counters.
module trigger_window_gen #(
   parameter int WIDTH_BITS = 10,
   parameter int DEAD_BITS  = 8,
   parameter int INDEX_BITS = 8,
   parameter int CNT_BITS   = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  trigger_in,
   input  logic                  enable_trigger,
   input  logic [WIDTH_BITS-1:0] trigger_width,
   input  logic [DEAD_BITS-1:0]  deadtime,
   output logic                  trigger,
   output logic [INDEX_BITS-1:0] trigger_index,
   output logic                  cycle_tick,
   output logic [CNT_BITS-1:0]   trigger_count,
   output logic [CNT_BITS-1:0]   trigger_lost_count
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WINDOW = 2'd1,
      ST_DEAD   = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic                  s1, s2, s3;
   logic                  edge_det;
   logic                  trigger_nxt;
   logic                  tick_nxt;
   logic [INDEX_BITS-1:0] index_nxt;
   logic [CNT_BITS-1:0]   count_nxt;
   logic [CNT_BITS-1:0]   lost_nxt;
   logic [WIDTH_BITS-1:0] len_q, len_nxt;
   logic [WIDTH_BITS-1:0] win_cnt, win_cnt_nxt;
   logic [DEAD_BITS-1:0]  dead_q, dead_nxt;
   logic [DEAD_BITS-1:0]  dead_cnt, dead_cnt_nxt;

   // Presetting the chain to ones means a level held high through reset never reads as an edge.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         s3 <= 1'b1;
      end else begin
         s1 <= trigger_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign edge_det = s2 & ~s3;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state              <= ST_IDLE;
         trigger            <= 1'b0;
         cycle_tick         <= 1'b0;
         trigger_index      <= '1;
         trigger_count      <= '0;
         trigger_lost_count <= '0;
         len_q              <= '0;
         win_cnt            <= '0;
         dead_q             <= '0;
         dead_cnt           <= '0;
      end else begin
         state              <= state_nxt;
         trigger            <= trigger_nxt;
         cycle_tick         <= tick_nxt;
         trigger_index      <= index_nxt;
         trigger_count      <= count_nxt;
         trigger_lost_count <= lost_nxt;
         len_q              <= len_nxt;
         win_cnt            <= win_cnt_nxt;
         dead_q             <= dead_nxt;
         dead_cnt           <= dead_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      trigger_nxt  = trigger;
      tick_nxt     = 1'b0;
      index_nxt    = trigger_index;
      count_nxt    = trigger_count;
      lost_nxt     = trigger_lost_count;
      len_nxt      = len_q;
      win_cnt_nxt  = win_cnt;
      dead_nxt     = dead_q;
      dead_cnt_nxt = dead_cnt;

      case (state)
         ST_IDLE: begin
            if (edge_det && enable_trigger) begin
               state_nxt   = ST_WINDOW;
               trigger_nxt = 1'b1;
               index_nxt   = trigger_index + 1'b1;
               count_nxt   = trigger_count + 1'b1;
               len_nxt     = (trigger_width == '0) ? WIDTH_BITS'(1) : trigger_width;
               win_cnt_nxt = WIDTH_BITS'(1);
            end
         end
         ST_WINDOW: begin
            // Deadtime is sampled here, at window close, not at acceptance.
            if (win_cnt == len_q) begin
               trigger_nxt  = 1'b0;
               tick_nxt     = 1'b1;
               dead_nxt     = deadtime;
               dead_cnt_nxt = DEAD_BITS'(1);
               state_nxt    = (deadtime != '0) ? ST_DEAD : ST_IDLE;
            end else begin
               win_cnt_nxt = win_cnt + 1'b1;
            end
         end
         ST_DEAD: begin
            if (dead_cnt == dead_q) begin
               state_nxt = ST_IDLE;
            end else begin
               dead_cnt_nxt = dead_cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      if (edge_det && (state != ST_IDLE) && (trigger_lost_count != '1)) begin
         lost_nxt = trigger_lost_count + 1'b1;
      end
   end

endmodule
